// File: rtl/string_frame_sequencer.sv
// string_frame_sequencer: pulls PIXELS_PER_STRING GRB words per frame from the pixel FIFO,
// strobes each into the WS2812B string driver, then requests the latch blank.
// Define STRING_SEQ_UNDERRUN_FILL_EN to send black pixels instead of stalling on FIFO underrun.
module string_frame_sequencer #(
    parameter int PIXELS_PER_STRING = 150,
    parameter int FIFO_LATENCY      = 1,
    parameter int READY_HOLDOFF     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [23:0] fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [23:0] pixel_data,
    output logic        pixel_data_valid,
    output logic        h_blank,
    input  logic        string_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_overrun,
    output logic        underrun
);
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FETCH     = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_LATCH     = 2'd3
    } state_t;

    localparam logic [9:0] LAST_PIXEL_C = 10'(PIXELS_PER_STRING - 1);
    localparam logic [1:0] FIFO_LAT_C   = 2'(FIFO_LATENCY);
    localparam logic [7:0] HOLDOFF_C    = 8'(READY_HOLDOFF);

    state_t      state_r, state_s;
    logic        pending_r, pending_s;
    logic [9:0]  count_r, count_s;
    logic [7:0]  holdoff_r, holdoff_s;
    logic [1:0]  wait_r, wait_s;
    logic        stall_seen_r, stall_seen_s;
    logic [23:0] pixel_data_r, pixel_data_s;
    logic        rd_en_r, rd_en_s;
    logic        valid_r, valid_s;
    logic        blank_r, blank_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        overrun_r, overrun_s;
    logic        underrun_r, underrun_s;
    logic        eff_ready_s;
    logic        last_pixel_s;

    // The driver's ready lags our strobes, so it is ignored until the holdoff expires.
    assign eff_ready_s  = string_ready && (holdoff_r == 8'd0);
    assign last_pixel_s = (count_r == LAST_PIXEL_C);

    // Next-state, one-deep frame queue and request pulse generation
    always_comb begin
        state_s      = state_r;
        pending_s    = pending_r;
        count_s      = count_r;
        wait_s       = wait_r;
        stall_seen_s = stall_seen_r;
        pixel_data_s = pixel_data_r;
        busy_s       = busy_r;
        rd_en_s      = 1'b0;
        valid_s      = 1'b0;
        blank_s      = 1'b0;
        done_s       = 1'b0;
        overrun_s    = 1'b0;
        underrun_s   = 1'b0;
        if (holdoff_r != 8'd0) begin
            holdoff_s = holdoff_r - 8'd1;
        end else begin
            holdoff_s = 8'd0;
        end

        if ((state_r != ST_IDLE) && frame_start) begin
            if (pending_r) begin
                overrun_s = 1'b1;
            end else begin
                pending_s = 1'b1;
            end
        end else begin
            overrun_s = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                // A start arriving alongside a queued one stays queued behind it.
                if (frame_start || pending_r) begin
                    pending_s    = pending_r && frame_start;
                    count_s      = 10'd0;
                    busy_s       = 1'b1;
                    stall_seen_s = 1'b0;
                    state_s      = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (eff_ready_s && !fifo_empty) begin
                    rd_en_s      = 1'b1;
                    wait_s       = 2'd0;
                    stall_seen_s = 1'b0;
                    state_s      = ST_WAIT_DATA;
                end else if (eff_ready_s) begin
`ifdef STRING_SEQ_UNDERRUN_FILL_EN
                    underrun_s   = 1'b1;
                    pixel_data_s = 24'h000000;
                    valid_s      = 1'b1;
                    holdoff_s    = HOLDOFF_C;
                    count_s      = count_r + 10'd1;
                    if (last_pixel_s) begin
                        state_s = ST_LATCH;
                    end else begin
                        state_s = ST_FETCH;
                    end
`else
                    if (!stall_seen_r) begin
                        underrun_s   = 1'b1;
                        stall_seen_s = 1'b1;
                    end else begin
                        underrun_s = 1'b0;
                    end
`endif
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_WAIT_DATA: begin
                if (wait_r == FIFO_LAT_C) begin
                    pixel_data_s = fifo_data;
                    valid_s      = 1'b1;
                    holdoff_s    = HOLDOFF_C;
                    count_s      = count_r + 10'd1;
                    if (last_pixel_s) begin
                        state_s = ST_LATCH;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else begin
                    wait_s = wait_r + 2'd1;
                end
            end
            ST_LATCH: begin
                if (eff_ready_s) begin
                    blank_s   = 1'b1;
                    done_s    = 1'b1;
                    busy_s    = 1'b0;
                    holdoff_s = HOLDOFF_C;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_LATCH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            pending_r    <= 1'b0;
            count_r      <= 10'd0;
            holdoff_r    <= 8'd0;
            wait_r       <= 2'd0;
            stall_seen_r <= 1'b0;
            pixel_data_r <= 24'h000000;
            rd_en_r      <= 1'b0;
            valid_r      <= 1'b0;
            blank_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            overrun_r    <= 1'b0;
            underrun_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            pending_r    <= pending_s;
            count_r      <= count_s;
            holdoff_r    <= holdoff_s;
            wait_r       <= wait_s;
            stall_seen_r <= stall_seen_s;
            pixel_data_r <= pixel_data_s;
            rd_en_r      <= rd_en_s;
            valid_r      <= valid_s;
            blank_r      <= blank_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            overrun_r    <= overrun_s;
            underrun_r   <= underrun_s;
        end
    end

    assign fifo_rd_en       = rd_en_r;
    assign pixel_data       = pixel_data_r;
    assign pixel_data_valid = valid_r;
    assign h_blank          = blank_r;
    assign busy             = busy_r;
    assign frame_done       = done_r;
    assign frame_overrun    = overrun_r;
    assign underrun         = underrun_r;

endmodule
